dir_ctrl: RTL and testbench
===========================

Name: dir_ctrl

Overview:
- Differential (tank-style) drive command decoder for the drone/rover motor path.
- Maps a 3-bit command (direction bit plus 2-bit speed level) to a pair of signed 16-bit setpoints, left_frwd and right_back, always of equal magnitude and opposite sign.
- Sits between the command interface and the motor PWM/speed controllers.
- Outputs are registered.

Parameters:
- WIDTH, 16, width of each signed setpoint output.
- SPEED_L1, 16'd102, magnitude for speed level 1.
- SPEED_L2, 16'd218, magnitude for speed level 2.
- SPEED_L3, 16'd402, magnitude for speed level 3.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- resetn  input  1  synchronous, active-high reset. The port keeps the codebase name; the reset is asserted when the signal is 1.
- cmds  input  3  cmds[2] = direction, cmds[1:0] = speed level (0 = stop, 1..3 = L1..L3).
- left_frwd  output  WIDTH  signed two's-complement setpoint, left/forward motor.
- right_back  output  WIDTH  signed two's-complement setpoint, right/back motor.

Behaviour:
- Reset: when resetn = 1 at a rising clk edge, left_frwd and right_back both load 0. Reset has priority over cmds. Asserting reset mid-operation zeroes both outputs at that edge.
- Magnitude decode, combinational:
  - cmds[1:0] = 00 -> mag = 0
  - 01 -> SPEED_L1
  - 10 -> SPEED_L2
  - 11 -> SPEED_L3
- Sign rules:
  - cmds[2] = 0: left_frwd = -mag, right_back = +mag.
  - cmds[2] = 1: left_frwd = +mag, right_back = -mag.
  - Negation is WIDTH-bit two's complement (~mag + 1), wrapping modulo 2^WIDTH.
  - mag = 0 yields 0 on both outputs regardless of direction; never 16'h10000 truncation artefacts.
- Latency: one cycle. cmds sampled at rising edge N (reset deasserted) appears on the outputs immediately after edge N. Outputs hold between edges.
- Invariant: left_frwd + right_back == 0 (mod 2^WIDTH) in every cycle.
- cmds containing X/Z is not required to be handled. Outputs may go X, but must recover on the first clean sample.
- No handshake, no internal state beyond the two output registers. No ramping, no saturation.
- Parameter legality: SPEED_Lx must be < 2^(WIDTH-1) so that both signs are representable.

Decomposition:
- Package dir_ctrl_pkg:
  - typedef struct packed {logic dir; logic [1:0] speed;} dir_cmd_t
  - typedef enum logic [1:0] {SPD_STOP, SPD_L1, SPD_L2, SPD_L3} speed_e
  - default speed constants 102/218/402
  - function neg16 (two's complement)
- Optional sub-module dir_speed_lut: combinational speed_e -> WIDTH-bit magnitude.
- Top dir_ctrl: sign selection plus output registers.

Test Plan:
- Reset: hold resetn = 1 with cmds = 3'b111 for 2 edges -> both outputs 16'h0000. Release reset -> outputs follow cmds one edge later.
- Reverse sweep: cmds 000, 001, 010, 011 on successive edges -> (left, right) = (0000, 0000), (FF9A, 0066), (FF26, 00DA), (FE6E, 0192).
- Forward sweep: cmds 100, 101, 110, 111 -> (0000, 0000), (0066, FF9A), (00DA, FF26), (0192, FE6E).
- Direction flip at full speed: cmds 011 then 111 on back-to-back edges -> outputs go (FE6E, 0192) then (0192, FE6E), each one cycle after the sample.
- Reset mid-run: cmds = 110 steady, assert resetn = 1 for one edge -> both outputs 0 at that edge, then (00DA, FF26) on the next edge after release.
- Invariant check every cycle of a random 200-cycle cmds sequence: left_frwd + right_back == 0 (mod 2^16), and |value| is one of {0, 102, 218, 402}.

Source files
------------

// File: rtl/dir_ctrl_pkg.sv
// Shared types and default speed magnitudes for the differential drive decoder.
package dir_ctrl_pkg;

    typedef struct packed {
        logic       dir;
        logic [1:0] speed;
    } dir_cmd_t;

    typedef enum logic [1:0] {
        SPD_STOP,
        SPD_L1,
        SPD_L2,
        SPD_L3
    } speed_e;

    localparam logic [15:0] SPEED_L1_DEF = 16'd102;
    localparam logic [15:0] SPEED_L2_DEF = 16'd218;
    localparam logic [15:0] SPEED_L3_DEF = 16'd402;

    // Wraps modulo 2^16, so zero maps back to zero.
    function automatic logic [15:0] neg16(input logic [15:0] v);
        return ~v + 16'd1;
    endfunction

endpackage

// File: rtl/dir_speed_lut.sv
// Combinational speed level to unsigned magnitude lookup.
module dir_speed_lut
    import dir_ctrl_pkg::*;
#(
    parameter int unsigned           WIDTH    = 16,
    parameter logic [WIDTH-1:0]      SPEED_L1 = WIDTH'(SPEED_L1_DEF),
    parameter logic [WIDTH-1:0]      SPEED_L2 = WIDTH'(SPEED_L2_DEF),
    parameter logic [WIDTH-1:0]      SPEED_L3 = WIDTH'(SPEED_L3_DEF)
) (
    input  speed_e           speed_i,
    output logic [WIDTH-1:0] mag_o
);

    always_comb begin
        mag_o = '0;
        unique case (speed_i)
            SPD_STOP: mag_o = '0;
            SPD_L1:   mag_o = SPEED_L1;
            SPD_L2:   mag_o = SPEED_L2;
            SPD_L3:   mag_o = SPEED_L3;
            default:  mag_o = '0;
        endcase
    end

endmodule

// File: rtl/dir_ctrl.sv
// Tank-style drive decoder: command to a pair of equal and opposite registered setpoints.
module dir_ctrl
    import dir_ctrl_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] SPEED_L1 = WIDTH'(SPEED_L1_DEF),
    parameter logic [WIDTH-1:0] SPEED_L2 = WIDTH'(SPEED_L2_DEF),
    parameter logic [WIDTH-1:0] SPEED_L3 = WIDTH'(SPEED_L3_DEF)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [2:0]       cmds,
    output logic [WIDTH-1:0] left_frwd,
    output logic [WIDTH-1:0] right_back
);

    dir_cmd_t         cmd;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] mag_neg;
    logic [WIDTH-1:0] left_d, left_q;
    logic [WIDTH-1:0] right_d, right_q;

    assign cmd = dir_cmd_t'(cmds);

    dir_speed_lut #(
        .WIDTH    (WIDTH),
        .SPEED_L1 (SPEED_L1),
        .SPEED_L2 (SPEED_L2),
        .SPEED_L3 (SPEED_L3)
    ) u_speed_lut (
        .speed_i (speed_e'(cmd.speed)),
        .mag_o   (mag)
    );

    // Two's complement at full width; a zero magnitude wraps back to zero.
    assign mag_neg = ~mag + WIDTH'(1);

    always_comb begin
        left_d  = mag_neg;
        right_d = mag;
        if (cmd.dir) begin
            left_d  = mag;
            right_d = mag_neg;
        end
    end

    // resetn is active-high despite its name.
    always_ff @(posedge clk) begin
        if (resetn) begin
            left_q  <= '0;
            right_q <= '0;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign left_frwd  = left_q;
    assign right_back = right_q;

endmodule

// File: tb/tb_dir_ctrl.sv
// Directed and randomized checks of dir_ctrl against an arithmetic reference model.
module tb_dir_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  cmds;
    logic [15:0] left_frwd;
    logic [15:0] right_back;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dir_ctrl u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmds       (cmds),
        .left_frwd  (left_frwd),
        .right_back (right_back)
    );

    // Signed setpoint from the command, computed as a plain integer then wrapped to 16 bits.
    function automatic logic [15:0] model_val(input logic [2:0] c, input bit is_left);
        int mags [4];
        int v;
        bit pos;
        mags[0] = 0;
        mags[1] = 102;
        mags[2] = 218;
        mags[3] = 402;
        v   = mags[c[1:0]];
        pos = is_left ? c[2] : !c[2];
        return 16'(pos ? v : -v);
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] c);
        resetn = r;
        cmds   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_chk(input string tag, input logic r, input logic [2:0] c,
                             input logic [15:0] exp_l, input logic [15:0] exp_r);
        drive(r, c);
        chk({tag, "_left"}, left_frwd, exp_l);
        chk({tag, "_right"}, right_back, exp_r);
    endtask

    initial begin
        logic        r;
        logic [2:0]  c;
        logic [15:0] exp_l, exp_r, held_l, held_r;
        int          a;
        bit          member;

        resetn = 1'b1;
        cmds   = 3'b111;

        drive_chk("reset0", 1'b1, 3'b111, 16'h0000, 16'h0000);
        drive_chk("reset1", 1'b1, 3'b111, 16'h0000, 16'h0000);

        drive_chk("rev0", 1'b0, 3'b000, 16'h0000, 16'h0000);
        drive_chk("rev1", 1'b0, 3'b001, 16'hFF9A, 16'h0066);
        drive_chk("rev2", 1'b0, 3'b010, 16'hFF26, 16'h00DA);
        drive_chk("rev3", 1'b0, 3'b011, 16'hFE6E, 16'h0192);

        drive_chk("fwd0", 1'b0, 3'b100, 16'h0000, 16'h0000);
        drive_chk("fwd1", 1'b0, 3'b101, 16'h0066, 16'hFF9A);
        drive_chk("fwd2", 1'b0, 3'b110, 16'h00DA, 16'hFF26);
        drive_chk("fwd3", 1'b0, 3'b111, 16'h0192, 16'hFE6E);

        drive_chk("flip_rev", 1'b0, 3'b011, 16'hFE6E, 16'h0192);
        drive_chk("flip_fwd", 1'b0, 3'b111, 16'h0192, 16'hFE6E);

        // Outputs must hold while cmds changes between edges.
        held_l = left_frwd;
        held_r = right_back;
        cmds   = 3'b001;
        #3;
        chk("hold_left", left_frwd, 16'h0192);
        chk("hold_right", right_back, 16'hFE6E);

        drive_chk("mid_pre", 1'b0, 3'b110, 16'h00DA, 16'hFF26);
        drive_chk("mid_rst", 1'b1, 3'b110, 16'h0000, 16'h0000);
        drive_chk("mid_post", 1'b0, 3'b110, 16'h00DA, 16'hFF26);

        for (int i = 0; i < 200; i++) begin
            r = ($urandom_range(0, 19) == 0);
            c = 3'($urandom_range(0, 7));
            exp_l = r ? 16'h0000 : model_val(c, 1'b1);
            exp_r = r ? 16'h0000 : model_val(c, 1'b0);
            drive_chk("rand", r, c, exp_l, exp_r);
            chk("rand_sum", left_frwd + right_back, 16'h0000);
            a = $signed(left_frwd);
            if (a < 0) a = -a;
            member = (a == 0) || (a == 102) || (a == 218) || (a == 402);
            chk("rand_magset", {15'd0, member}, 16'h0001);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
